// File: rtl/data_memory_lsu_pkg.sv
// dmem_pkg: funct3 and fault-cause encodings shared by the data memory LSU
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MIS_LD  = 2'b01;
  localparam logic [1:0] CAUSE_MIS_ST  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;
endpackage

// File: rtl/data_memory_lsu_load_align.sv
// lsu_load_align: selects the addressed lane of a word and sign/zero-extends it
module lsu_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] rd
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b  = word[8*lane +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    rd = funct3 == F3_B  ? {{24{b[7]}}, b}  :
         funct3 == F3_H  ? {{16{h[15]}}, h} :
         funct3 == F3_W  ? word             :
         funct3 == F3_BU ? {24'b0, b}       :
         funct3 == F3_HU ? {16'b0, h}       : 32'b0;
  end
endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed data RAM with store byte enables, load alignment and sticky fault capture
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        FaultClear,
  output logic [31:0] ReadData,
  output logic        FaultValid,
  output logic [1:0]  FaultCause,
  output logic [31:0] FaultAddr
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0] lane;
  logic [31:0] aligned, wdata;
  logic [3:0] be;
  logic ld, st, mis, ld_ill, st_ill, illegal, mis_ld, mis_st, fault, we;
  logic [1:0] cause;
  logic unused_addr;
  assign unused_addr = ^ALUResult[31:AW+2];
  assign widx = ALUResult[AW+1:2];
  assign lane = ALUResult[1:0];
  lsu_load_align u_align (.word(mem[widx]), .lane(lane), .funct3(funct3), .rd(aligned));
  always_comb begin
    ld      = MemRead & ~MemWrite;
    st      = MemWrite & ~MemRead;
    mis     = (funct3[1:0] == 2'b01 & lane[0]) | (funct3[1:0] == 2'b10 & lane != 2'b00);
    ld_ill  = ld & (funct3 == 3'b011 | funct3 == 3'b110 | funct3 == 3'b111);
    st_ill  = st & (funct3[2] | funct3 == 3'b011);
    illegal = ld_ill | st_ill | (MemRead & MemWrite);
    mis_ld  = ld & ~ld_ill & mis;
    mis_st  = st & ~st_ill & mis;
    fault   = illegal | mis_ld | mis_st;
    cause   = illegal ? CAUSE_ILLEGAL : mis_st ? CAUSE_MIS_ST : mis_ld ? CAUSE_MIS_LD : CAUSE_NONE;
    we      = st & ~fault;
    be      = funct3 == F3_B ? 4'b0001 << lane : funct3 == F3_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata   = funct3 == F3_B ? {4{WriteData[7:0]}} : funct3 == F3_H ? {2{WriteData[15:0]}} : WriteData;
    ReadData = (illegal | mis_ld) ? 32'b0 : aligned;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      FaultValid <= 1'b0;
      FaultCause <= CAUSE_NONE;
      FaultAddr  <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (we & be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      if (fault & (~FaultValid | FaultClear)) begin
        FaultValid <= 1'b1;
        FaultCause <= cause;
        FaultAddr  <= ALUResult;
      end else if (FaultClear) begin
        FaultValid <= 1'b0;
        FaultCause <= CAUSE_NONE;
        FaultAddr  <= '0;
      end
    end
  end
endmodule
